// File: rtl/lae_ctrl.sv
// Sequencing controller for the shared 4-share FIDES-160 round datapath (lae_comb).
// Issues one control word per clock: init rounds, one absorb per block, final rounds, tag strobe.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start, all controls low, rcon shows the seed
// S_INIT  | init load on counter 0, then N_INIT-1 plain rounds
// S_DATA  | one block absorbed per cycle, a missing block aborts with err
// S_FINAL | N_FINAL plain rounds
// S_TAG   | single tag-strobe cycle, done follows in the next IDLE cycle
module lae_ctrl #(
  parameter int          N_INIT  = 16,
  parameter int          N_FINAL = 16,
  parameter logic [4:0]  RC_SEED = 5'h01
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       start,
  input  logic       din_valid,
  input  logic       din_type,
  input  logic       din_last,
  output logic       din_ready,
  output logic       init,
  output logic       getdata0,
  output logic       getdata,
  output logic       outc,
  output logic       final_o,
  output logic [4:0] rcon,
  output logic       c_valid,
  output logic       tag_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_DATA, S_FINAL, S_TAG} state_t;

  localparam logic [4:0] INIT_LAST  = 5'(N_INIT - 1);
  localparam logic [4:0] FINAL_LAST = 5'(N_FINAL - 1);

  state_t     state_q;
  logic [4:0] cnt_q;
  logic [4:0] lfsr_q;
  logic [4:0] lfsr_d;
  logic       first_q;
  logic       done_q;
  logic       err_q;
  logic       blk;

  // x^5 + x^3 + 1, period 31
  assign lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[1]};

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      lfsr_q  <= RC_SEED;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE) lfsr_q <= lfsr_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_INIT;
            cnt_q   <= 5'd0;
            lfsr_q  <= RC_SEED;
            err_q   <= 1'b0;
          end
        end
        S_INIT: begin
          if (cnt_q == INIT_LAST) begin
            state_q <= S_DATA;
            first_q <= 1'b1;
            cnt_q   <= 5'd0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        S_DATA: begin
          if (!din_valid) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            first_q <= 1'b0;
            if (din_last) begin
              state_q <= S_FINAL;
              cnt_q   <= 5'd0;
            end
          end
        end
        S_FINAL: begin
          if (cnt_q == FINAL_LAST) begin
            state_q <= S_TAG;
            cnt_q   <= 5'd0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        S_TAG: begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Absorb controls follow din_valid in the same cycle; a gap cycle drives nothing.
  assign blk       = (state_q == S_DATA) && din_valid;
  assign din_ready = (state_q == S_DATA);
  assign init      = (state_q == S_INIT) && (cnt_q == 5'd0);
  assign getdata0  = blk && first_q;
  assign getdata   = blk && !first_q;
  assign outc      = blk && din_type;
  assign c_valid   = outc;
  assign final_o   = (state_q == S_TAG);
  assign tag_valid = final_o;
  assign busy      = (state_q != S_IDLE);
  assign rcon      = busy ? lfsr_q : RC_SEED;
  assign done      = done_q;
  assign err       = err_q;

endmodule
